regfile_renamed: RTL and testbench
==================================

Name: regfile_renamed

Overview:
- Parametrised architectural register file with rename tracking for the out-of-order core.
- Each register holds a value, a busy bit and the ROB tag of its youngest in-flight producer.
- Decode/issue renames destinations. ROB commit writes values back and releases tags. Branch mispredict flush clears all renames.
- NRD combinational read ports feed the reservation stations and the load/store buffer. Reads have same-cycle commit forwarding.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (register 0 hardwired to zero)
REG_W, 5, register index width, equal to ceil(log2(NREG))
TAG_W, 4, ROB tag width
NRD, 2, number of read ports

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  ready; when low, all state updates are frozen
iss_valid  input  1  rename destination this cycle
iss_rd  input  REG_W  destination register being renamed
iss_tag  input  TAG_W  ROB tag assigned to that destination
cmt_valid  input  1  ROB commit this cycle
cmt_rd  input  REG_W  committed destination register
cmt_tag  input  TAG_W  ROB tag of committing entry
cmt_val  input  XLEN  committed result value
flush  input  1  mispredict: discard all renames
rd_idx  input  NRD*REG_W  read indices; port k occupies bits [k*REG_W +: REG_W]
rd_val  output  NRD*XLEN  read values, packed the same way
rd_busy  output  NRD  per-port busy flag (value not yet committed)
rd_tag  output  NRD*TAG_W  per-port producer tag; meaningful only when busy

Behaviour:
- Clocking and reset: one clock (clk_in). Reset is synchronous and active-high (rst_in).
- Reset (rst_in=1 at posedge): all values=0, busy=0, tag=0. Reset has priority over rdy_in and all requests. Reset during in-flight renames simply discards them.
- Reads are combinational, zero latency, evaluated independently per port k:
  - idx=0: val=0, busy=0, tag=0.
  - Commit forwarding: if cmt_valid && rdy_in && cmt_rd==idx && idx!=0, then val=cmt_val; otherwise val=stored value.
  - busy = stored busy && !(forwarding active && cmt_tag==stored tag) && !(flush && rdy_in).
  - tag = stored tag.
  - Reads never see same-cycle issue. An instruction reads its sources before its own rename takes effect.
- Sequential update at posedge, when !rst_in && rdy_in, in priority order:
  1. Commit: if cmt_valid && cmt_rd!=0, value[cmt_rd] <= cmt_val. If additionally busy[cmt_rd] && tag[cmt_rd]==cmt_tag, clear busy[cmt_rd]. A tag mismatch means a younger producer exists, so busy and tag are kept.
  2. Flush: if flush, busy <= 0 for every register. Tags are left unchanged (don't care). The commit value write in the same cycle still occurs.
  3. Issue: if iss_valid && !flush && iss_rd!=0, busy[iss_rd] <= 1 and tag[iss_rd] <= iss_tag. Issue overrides a same-cycle commit clear on the same register.
- Issue during flush is dropped.
- Writes and issues to register 0 are ignored. Register 0 is never busy.
- rdy_in=0: no state change. Read outputs stay live, but forwarding and flush masking are disabled.
- Re-issue to an already-busy register overwrites the tag (youngest producer wins).
- Tag width arithmetic: only equality compares. There is no wrap handling; ROB tag recycling is the ROB's responsibility.

Test Plan:
- Reset, then read x0..x31 on both ports -> all val=0, busy=0. Commit x0=0xDEADBEEF -> x0 still reads 0 and is not busy.
- Issue x5 tag 3; next cycle read x5 -> busy=1, tag=3. Commit x5 tag 3 val 0x1234 -> same-cycle read gives val=0x1234, busy=0; next cycle stored busy=0.
- Issue x7 tag 2, then issue x7 tag 9. Commit x7 tag 2 val 0x55 -> value=0x55, busy stays 1, tag=9.
- Same cycle: commit x4 tag 1 val 0xAA (x4 busy tag 1) and issue x4 tag 6 -> next cycle val=0xAA, busy=1, tag=6.
- x3, x8, x9 busy; flush with issue x10 tag 5 and commit x8 val 7 in the same cycle -> all busy=0 (x10 not busy), x8 val=7.
- rdy_in=0 with issue x6 tag 4 and commit x2 val 9 -> no state change, rd_val for x2 not forwarded. rst_in asserted while x6 busy -> next cycle all val=0, busy=0.

Source files
------------

// File: rtl/regfile_renamed.sv
// Architectural register file with per-register busy bit and youngest-producer ROB tag.
// Reads are combinational with same-cycle commit forwarding; writes take effect at the next edge; rdy_in low freezes all state.
module regfile_renamed #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int REG_W = 5,
    parameter int TAG_W = 4,
    parameter int NRD   = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   iss_valid,
    input  logic [REG_W-1:0]       iss_rd,
    input  logic [TAG_W-1:0]       iss_tag,
    input  logic                   cmt_valid,
    input  logic [REG_W-1:0]       cmt_rd,
    input  logic [TAG_W-1:0]       cmt_tag,
    input  logic [XLEN-1:0]        cmt_val,
    input  logic                   flush,
    input  logic [NRD*REG_W-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0]    rd_val,
    output logic [NRD-1:0]         rd_busy,
    output logic [NRD*TAG_W-1:0]   rd_tag
);

    logic [XLEN-1:0]  val_q  [NREG];
    logic [XLEN-1:0]  val_d  [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    logic cmt_en;
    logic iss_en;

    assign cmt_en = rdy_in && cmt_valid && (cmt_rd != '0);
    assign iss_en = rdy_in && iss_valid && !flush && (iss_rd != '0);

    // Commit, then flush, then issue: later steps override earlier ones on busy/tag.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (cmt_en) begin
            val_d[cmt_rd] = cmt_val;
            if (busy_q[cmt_rd] && (tag_q[cmt_rd] == cmt_tag)) begin
                busy_d[cmt_rd] = 1'b0;
            end
        end
        if (rdy_in && flush) begin
            busy_d = '0;
        end
        if (iss_en) begin
            busy_d[iss_rd] = 1'b1;
            tag_d[iss_rd]  = iss_tag;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    // Read ports see stored state plus the in-flight commit, never the same-cycle issue.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [REG_W-1:0] idx;
        logic             nz;
        logic             fwd;

        assign idx = rd_idx[k*REG_W +: REG_W];
        assign nz  = (idx != '0);
        assign fwd = nz && cmt_valid && rdy_in && (cmt_rd == idx);

        assign rd_val[k*XLEN +: XLEN]   = !nz ? '0 : (fwd ? cmt_val : val_q[idx]);
        assign rd_busy[k]               = nz && busy_q[idx]
                                          && !(fwd && (cmt_tag == tag_q[idx]))
                                          && !(flush && rdy_in);
        assign rd_tag[k*TAG_W +: TAG_W] = !nz ? '0 : tag_q[idx];
    end

endmodule

// File: tb/tb_regfile_renamed.sv
// Directed bench for regfile_renamed: expected read results are queued as each step is driven and checked against the ports.
module tb_regfile_renamed;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int TAG_W = 4;
    localparam int NRD   = 2;

    logic                 clk_in = 1'b0;
    logic                 rst_in, rdy_in;
    logic                 iss_valid, cmt_valid, flush;
    logic [REG_W-1:0]     iss_rd, cmt_rd;
    logic [TAG_W-1:0]     iss_tag, cmt_tag;
    logic [XLEN-1:0]      cmt_val;
    logic [NRD*REG_W-1:0] rd_idx;
    logic [NRD*XLEN-1:0]  rd_val;
    logic [NRD-1:0]       rd_busy;
    logic [NRD*TAG_W-1:0] rd_tag;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int               port;
        logic [XLEN-1:0]  v;
        logic             b;
        logic [TAG_W-1:0] t;
        logic             ct;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];

    regfile_renamed #(.XLEN(XLEN), .NREG(NREG), .REG_W(REG_W), .TAG_W(TAG_W), .NRD(NRD)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
        .flush(flush), .rd_idx(rd_idx), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; iss_tag = '0;
        cmt_valid = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
    endtask

    task automatic issue(input int r, input int t);
        iss_valid = 1'b1; iss_rd = REG_W'(r); iss_tag = TAG_W'(t);
    endtask

    task automatic commit(input int r, input int t, input logic [XLEN-1:0] v);
        cmt_valid = 1'b1; cmt_rd = REG_W'(r); cmt_tag = TAG_W'(t); cmt_val = v;
    endtask

    // Point port k at register r and queue the values that port must show.
    task automatic rd(input int k, input int r, input logic [XLEN-1:0] v, input logic b,
                      input logic [TAG_W-1:0] t, input logic ct, input string nm);
        exp_t e;
        rd_idx[k*REG_W +: REG_W] = REG_W'(r);
        e.port = k; e.v = v; e.b = b; e.t = t; e.ct = ct;
        exp_q.push_back(e);
        nm_q.push_back($sformatf("%s_x%0d_p%0d", nm, r, k));
    endtask

    task automatic check_now();
        exp_t             e;
        string            nm;
        logic [XLEN-1:0]  av;
        logic             ab;
        logic [TAG_W-1:0] at;
        #1;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            av = rd_val[e.port*XLEN +: XLEN];
            ab = rd_busy[e.port];
            at = rd_tag[e.port*TAG_W +: TAG_W];
            n_vec++;
            assert (av === e.v) else begin
                n_err++;
                $error("FAIL %s val: got %h expected %h", nm, av, e.v);
            end
            n_vec++;
            assert (ab === e.b) else begin
                n_err++;
                $error("FAIL %s busy: got %b expected %b", nm, ab, e.b);
            end
            if (e.ct) begin
                n_vec++;
                assert (at === e.t) else begin
                    n_err++;
                    $error("FAIL %s tag: got %0d expected %0d", nm, at, e.t);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
        idle();
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        rd_idx = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        idle();

        for (int i = 0; i < NREG; i++) begin
            rd(0, i, 32'h0, 1'b0, 4'd0, 1'b1, "rst");
            rd(1, NREG - 1 - i, 32'h0, 1'b0, 4'd0, 1'b1, "rst");
            check_now();
        end

        commit(0, 0, 32'hDEADBEEF);
        issue(0, 5);
        rd(0, 0, 32'h0, 1'b0, 4'd0, 1'b1, "x0cmt");
        check_now();
        tick();
        rd(0, 0, 32'h0, 1'b0, 4'd0, 1'b1, "x0after");
        check_now();

        issue(5, 3);
        rd(0, 5, 32'h0, 1'b0, 4'd0, 1'b1, "noissfwd");
        check_now();
        tick();
        rd(0, 5, 32'h0, 1'b1, 4'd3, 1'b1, "x5busy");
        check_now();
        commit(5, 3, 32'h1234);
        rd(0, 5, 32'h1234, 1'b0, 4'd3, 1'b1, "x5fwd");
        rd(1, 5, 32'h1234, 1'b0, 4'd3, 1'b1, "x5fwd");
        check_now();
        tick();
        rd(0, 5, 32'h1234, 1'b0, 4'd3, 1'b1, "x5done");
        check_now();

        issue(7, 2);
        tick();
        issue(7, 9);
        tick();
        commit(7, 2, 32'h55);
        rd(0, 7, 32'h55, 1'b1, 4'd9, 1'b1, "x7stale");
        check_now();
        tick();
        rd(1, 7, 32'h55, 1'b1, 4'd9, 1'b1, "x7young");
        check_now();

        issue(4, 1);
        tick();
        commit(4, 1, 32'hAA);
        issue(4, 6);
        rd(0, 4, 32'hAA, 1'b0, 4'd1, 1'b1, "x4same");
        check_now();
        tick();
        rd(0, 4, 32'hAA, 1'b1, 4'd6, 1'b1, "x4reiss");
        check_now();

        issue(3, 1);
        tick();
        issue(8, 2);
        tick();
        issue(9, 3);
        tick();
        rd(0, 8, 32'h0, 1'b1, 4'd2, 1'b1, "preflush");
        rd(1, 9, 32'h0, 1'b1, 4'd3, 1'b1, "preflush");
        check_now();
        flush = 1'b1;
        issue(10, 5);
        commit(8, 0, 32'h7);
        rd(0, 8, 32'h7, 1'b0, 4'd2, 1'b1, "flushfwd");
        rd(1, 3, 32'h0, 1'b0, 4'd1, 1'b1, "flushmask");
        check_now();
        tick();
        for (int i = 1; i < NREG; i++) begin
            rd(0, i, (i == 8) ? 32'h7 : (i == 7) ? 32'h55 : (i == 5) ? 32'h1234 :
                     (i == 4) ? 32'hAA : 32'h0, 1'b0, 4'd0, 1'b0, "postflush");
            check_now();
        end

        issue(11, 7);
        tick();
        rdy_in = 1'b0;
        flush = 1'b1;
        issue(6, 4);
        commit(2, 0, 32'h9);
        rd(0, 2, 32'h0, 1'b0, 4'd0, 1'b1, "stallfwd");
        rd(1, 11, 32'h0, 1'b1, 4'd7, 1'b1, "stallmask");
        check_now();
        tick();
        rd(0, 6, 32'h0, 1'b0, 4'd0, 1'b1, "frozen");
        rd(1, 2, 32'h0, 1'b0, 4'd0, 1'b1, "frozen");
        check_now();
        rd(0, 11, 32'h0, 1'b1, 4'd7, 1'b1, "frozen");
        check_now();

        issue(6, 4);
        tick();
        rd(0, 6, 32'h0, 1'b1, 4'd4, 1'b1, "x6busy");
        check_now();
        rst_in = 1'b1;
        commit(12, 0, 32'h77);
        issue(13, 2);
        tick();
        for (int i = 0; i < NREG; i++) begin
            rd(0, i, 32'h0, 1'b0, 4'd0, 1'b1, "rst2");
            rd(1, NREG - 1 - i, 32'h0, 1'b0, 4'd0, 1'b1, "rst2");
            check_now();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
